gem_csc_cluster_matcher: RTL

Buffers the GEM clusters of one bunch crossing after their conversion to CSC wire-group and 1/8-strip (xky) windows. On an LCT request, it scans the buffer one entry per cycle and returns the best-matching cluster. It sits directly downstream of the cluster-to-CSC coordinate converter and upstream of the GEM-CSC LCT builder.

---
 rtl/gem_csc_cluster_matcher_if.sv | 58 +++++
 rtl/gem_csc_cluster_matcher.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_csc_cluster_matcher_if.sv
// Bus between the cluster-to-CSC converter, the LCT builder and the GEM-CSC cluster matcher.
// The master modport is the upstream/downstream side; the matcher uses the slave modport.
interface gem_csc_cluster_matcher_if #(
  parameter int IDXB     = 3,
  parameter int MXXKYB   = 10,
  parameter int WIREBITS = 7
);
  logic                bx0;
  logic                clst_vpf;
  logic                clst_me1a;
  logic [WIREBITS-1:0] clst_wire_lo;
  logic [WIREBITS-1:0] clst_wire_hi;
  logic [WIREBITS-1:0] clst_wire_mi;
  logic [MXXKYB-1:0]   clst_xky_lo;
  logic [MXXKYB-1:0]   clst_xky_hi;
  logic [MXXKYB-1:0]   clst_xky_mi;
  logic [13:0]         clst_word;
  logic [2:0]          clst_roll;
  logic [7:0]          clst_pad;
  logic [2:0]          clst_size;
  logic                lct_req;
  logic                alct_vpf;
  logic [WIREBITS-1:0] alct_wire;
  logic                clct_vpf;
  logic [MXXKYB-1:0]   clct_xky;
  logic                clct_me1a;
  logic                lct_busy;
  logic                match_done;
  logic                match_abort;
  logic                match_vpf;
  logic [IDXB-1:0]     match_idx;
  logic [13:0]         match_word;
  logic [2:0]          match_roll;
  logic [7:0]          match_pad;
  logic [2:0]          match_size;
  logic [MXXKYB-1:0]   match_dxky;
  logic [WIREBITS-1:0] match_dwire;
  logic [IDXB:0]       clst_count;
  logic                clst_ovf;

  modport master (
    output bx0, clst_vpf, clst_me1a, clst_wire_lo, clst_wire_hi, clst_wire_mi,
           clst_xky_lo, clst_xky_hi, clst_xky_mi, clst_word, clst_roll, clst_pad,
           clst_size, lct_req, alct_vpf, alct_wire, clct_vpf, clct_xky, clct_me1a,
    input  lct_busy, match_done, match_abort, match_vpf, match_idx, match_word,
           match_roll, match_pad, match_size, match_dxky, match_dwire, clst_count,
           clst_ovf
  );

  modport slave (
    input  bx0, clst_vpf, clst_me1a, clst_wire_lo, clst_wire_hi, clst_wire_mi,
           clst_xky_lo, clst_xky_hi, clst_xky_mi, clst_word, clst_roll, clst_pad,
           clst_size, lct_req, alct_vpf, alct_wire, clct_vpf, clct_xky, clct_me1a,
    output lct_busy, match_done, match_abort, match_vpf, match_idx, match_word,
           match_roll, match_pad, match_size, match_dxky, match_dwire, clst_count,
           clst_ovf
  );
endinterface

// File: rtl/gem_csc_cluster_matcher.sv
// Per-BX buffer of converted GEM clusters; on an LCT request it scans one entry per cycle
// and returns the in-window cluster closest to the ALCT/CLCT key (lowest index wins ties).
module gem_csc_cluster_matcher #(
  parameter int MXCLST   = 8,
  parameter int IDXB     = 3,
  parameter int MXXKYB   = 10,
  parameter int WIREBITS = 7
) (
  input logic                      clock,
  input logic                      reset_n,
  gem_csc_cluster_matcher_if.slave bus
);

  localparam int SCB = MXXKYB + 1;
  localparam logic [IDXB:0] CNT_ONE = (IDXB+1)'(1);
  localparam logic [IDXB:0] CNT_MAX = (IDXB+1)'(MXCLST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [MXXKYB-1:0] dist_xky(input logic [MXXKYB-1:0] a,
                                                 input logic [MXXKYB-1:0] b);
    if (a >= b) return a - b;
    else return b - a;
  endfunction

  function automatic logic [WIREBITS-1:0] dist_wire(input logic [WIREBITS-1:0] a,
                                                    input logic [WIREBITS-1:0] b);
    if (a >= b) return a - b;
    else return b - a;
  endfunction

  // buffer storage
  logic                r_b_me1a    [MXCLST];
  logic [WIREBITS-1:0] r_b_wire_lo [MXCLST];
  logic [WIREBITS-1:0] r_b_wire_hi [MXCLST];
  logic [WIREBITS-1:0] r_b_wire_mi [MXCLST];
  logic [MXXKYB-1:0]   r_b_xky_lo  [MXCLST];
  logic [MXXKYB-1:0]   r_b_xky_hi  [MXCLST];
  logic [MXXKYB-1:0]   r_b_xky_mi  [MXCLST];
  logic [13:0]         r_b_word    [MXCLST];
  logic [2:0]          r_b_roll    [MXCLST];
  logic [7:0]          r_b_pad     [MXCLST];
  logic [2:0]          r_b_size    [MXCLST];

  logic [IDXB:0]       r_count;
  logic                r_ovf;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic                w_abort;

  logic                r_alct_vpf;
  logic [WIREBITS-1:0] r_alct_wire;
  logic                r_clct_vpf;
  logic [MXXKYB-1:0]   r_clct_xky;
  logic                r_clct_me1a;
  logic [IDXB:0]       r_n;
  logic [IDXB-1:0]     r_ptr;

  logic                r_best_vld;
  logic [IDXB-1:0]     r_best_idx;
  logic [SCB-1:0]      r_best_score;
  logic [MXXKYB-1:0]   r_best_dxky;
  logic [WIREBITS-1:0] r_best_dwire;

  logic                r_match_done;
  logic                r_match_abort;
  logic                r_match_vpf;
  logic [IDXB-1:0]     r_match_idx;
  logic [13:0]         r_match_word;
  logic [2:0]          r_match_roll;
  logic [7:0]          r_match_pad;
  logic [2:0]          r_match_size;
  logic [MXXKYB-1:0]   r_match_dxky;
  logic [WIREBITS-1:0] r_match_dwire;

  logic                w_room;
  logic                w_wr_en;
  logic [IDXB-1:0]     w_wr_idx;
  logic                w_empty_req;

  logic                w_e_me1a;
  logic [WIREBITS-1:0] w_e_wire_lo;
  logic [WIREBITS-1:0] w_e_wire_hi;
  logic [WIREBITS-1:0] w_e_wire_mi;
  logic [MXXKYB-1:0]   w_e_xky_lo;
  logic [MXXKYB-1:0]   w_e_xky_hi;
  logic [MXXKYB-1:0]   w_e_xky_mi;
  logic                w_q_me;
  logic                w_q_xky;
  logic                w_q_wire;
  logic [MXXKYB-1:0]   w_dxky;
  logic [WIREBITS-1:0] w_dwire;
  logic [SCB-1:0]      w_score;
  logic                w_take;
  logic                w_last;

  logic                w_fin_vld;
  logic [IDXB-1:0]     w_fin_idx;
  logic [MXXKYB-1:0]   w_fin_dxky;
  logic [WIREBITS-1:0] w_fin_dwire;

  // bx0 retargets a simultaneous write to index 0 of the freshly cleared buffer
  assign w_room   = (r_count < CNT_MAX);
  assign w_wr_en  = bus.clst_vpf && (bus.bx0 || w_room);
  assign w_wr_idx = bus.bx0 ? {IDXB{1'b0}} : r_count[IDXB-1:0];
  assign w_empty_req = (r_count == {(IDXB+1){1'b0}}) || (!bus.alct_vpf && !bus.clct_vpf);

  assign w_e_me1a    = r_b_me1a[r_ptr];
  assign w_e_wire_lo = r_b_wire_lo[r_ptr];
  assign w_e_wire_hi = r_b_wire_hi[r_ptr];
  assign w_e_wire_mi = r_b_wire_mi[r_ptr];
  assign w_e_xky_lo  = r_b_xky_lo[r_ptr];
  assign w_e_xky_hi  = r_b_xky_hi[r_ptr];
  assign w_e_xky_mi  = r_b_xky_mi[r_ptr];

  assign w_q_me   = !r_clct_vpf || (w_e_me1a == r_clct_me1a);
  assign w_q_xky  = !r_clct_vpf || ((w_e_xky_lo <= r_clct_xky) && (r_clct_xky <= w_e_xky_hi));
  assign w_q_wire = !r_alct_vpf || ((w_e_wire_lo <= r_alct_wire) && (r_alct_wire <= w_e_wire_hi));
  assign w_dxky   = r_clct_vpf ? dist_xky(r_clct_xky, w_e_xky_mi) : {MXXKYB{1'b0}};
  assign w_dwire  = r_alct_vpf ? dist_wire(r_alct_wire, w_e_wire_mi) : {WIREBITS{1'b0}};
  assign w_score  = {1'b0, w_dxky} + SCB'(w_dwire);
  assign w_take   = w_q_me && w_q_xky && w_q_wire && (!r_best_vld || (w_score < r_best_score));
  assign w_last   = (({1'b0, r_ptr} + CNT_ONE) == r_n);

  // the final result folds in the entry being evaluated on the last scan cycle
  assign w_fin_vld   = (r_state == S_SCAN) && (w_take || r_best_vld);
  assign w_fin_idx   = w_take ? r_ptr : r_best_idx;
  assign w_fin_dxky  = w_take ? w_dxky : r_best_dxky;
  assign w_fin_dwire = w_take ? w_dwire : r_best_dwire;

  // buffer payload write; validity is tracked by r_count only
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_b_me1a[w_wr_idx]    <= bus.clst_me1a;
      r_b_wire_lo[w_wr_idx] <= bus.clst_wire_lo;
      r_b_wire_hi[w_wr_idx] <= bus.clst_wire_hi;
      r_b_wire_mi[w_wr_idx] <= bus.clst_wire_mi;
      r_b_xky_lo[w_wr_idx]  <= bus.clst_xky_lo;
      r_b_xky_hi[w_wr_idx]  <= bus.clst_xky_hi;
      r_b_xky_mi[w_wr_idx]  <= bus.clst_xky_mi;
      r_b_word[w_wr_idx]    <= bus.clst_word;
      r_b_roll[w_wr_idx]    <= bus.clst_roll;
      r_b_pad[w_wr_idx]     <= bus.clst_pad;
      r_b_size[w_wr_idx]    <= bus.clst_size;
    end
  end

  // entry count and sticky overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {(IDXB+1){1'b0}};
      r_ovf   <= 1'b0;
    end else if (bus.bx0) begin
      r_count <= bus.clst_vpf ? CNT_ONE : {(IDXB+1){1'b0}};
      r_ovf   <= 1'b0;
    end else if (bus.clst_vpf) begin
      if (w_room) r_count <= r_count + CNT_ONE;
      else r_ovf <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  // FSM next state, result load and abort strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.lct_req) begin
          if (w_empty_req) begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_SCAN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (bus.bx0) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (bus.bx0) w_abort = 1'b1;
        else w_abort = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // request latch, scan pointer and running best
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alct_vpf   <= 1'b0;
      r_alct_wire  <= {WIREBITS{1'b0}};
      r_clct_vpf   <= 1'b0;
      r_clct_xky   <= {MXXKYB{1'b0}};
      r_clct_me1a  <= 1'b0;
      r_n          <= {(IDXB+1){1'b0}};
      r_ptr        <= {IDXB{1'b0}};
      r_best_vld   <= 1'b0;
      r_best_idx   <= {IDXB{1'b0}};
      r_best_score <= {SCB{1'b0}};
      r_best_dxky  <= {MXXKYB{1'b0}};
      r_best_dwire <= {WIREBITS{1'b0}};
    end else if ((r_state == S_IDLE) && bus.lct_req) begin
      r_alct_vpf   <= bus.alct_vpf;
      r_alct_wire  <= bus.alct_wire;
      r_clct_vpf   <= bus.clct_vpf;
      r_clct_xky   <= bus.clct_xky;
      r_clct_me1a  <= bus.clct_me1a;
      r_n          <= r_count;
      r_ptr        <= {IDXB{1'b0}};
      r_best_vld   <= 1'b0;
      r_best_idx   <= {IDXB{1'b0}};
      r_best_score <= {SCB{1'b0}};
      r_best_dxky  <= {MXXKYB{1'b0}};
      r_best_dwire <= {WIREBITS{1'b0}};
    end else if (r_state == S_SCAN) begin
      r_ptr <= r_ptr + {{(IDXB-1){1'b0}}, 1'b1};
      if (w_take) begin
        r_best_vld   <= 1'b1;
        r_best_idx   <= r_ptr;
        r_best_score <= w_score;
        r_best_dxky  <= w_dxky;
        r_best_dwire <= w_dwire;
      end
    end
  end

  // registered result; an empty result clears every field
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_match_done  <= 1'b0;
      r_match_abort <= 1'b0;
      r_match_vpf   <= 1'b0;
      r_match_idx   <= {IDXB{1'b0}};
      r_match_word  <= 14'd0;
      r_match_roll  <= 3'd0;
      r_match_pad   <= 8'd0;
      r_match_size  <= 3'd0;
      r_match_dxky  <= {MXXKYB{1'b0}};
      r_match_dwire <= {WIREBITS{1'b0}};
    end else begin
      r_match_done  <= w_load;
      r_match_abort <= w_abort;
      if (w_load) begin
        r_match_vpf   <= w_fin_vld;
        r_match_idx   <= w_fin_vld ? w_fin_idx : {IDXB{1'b0}};
        r_match_word  <= w_fin_vld ? r_b_word[w_fin_idx] : 14'd0;
        r_match_roll  <= w_fin_vld ? r_b_roll[w_fin_idx] : 3'd0;
        r_match_pad   <= w_fin_vld ? r_b_pad[w_fin_idx] : 8'd0;
        r_match_size  <= w_fin_vld ? r_b_size[w_fin_idx] : 3'd0;
        r_match_dxky  <= w_fin_vld ? w_fin_dxky : {MXXKYB{1'b0}};
        r_match_dwire <= w_fin_vld ? w_fin_dwire : {WIREBITS{1'b0}};
      end
    end
  end

  assign bus.lct_busy    = (r_state != S_IDLE);
  assign bus.match_done  = r_match_done;
  assign bus.match_abort = r_match_abort;
  assign bus.match_vpf   = r_match_vpf;
  assign bus.match_idx   = r_match_idx;
  assign bus.match_word  = r_match_word;
  assign bus.match_roll  = r_match_roll;
  assign bus.match_pad   = r_match_pad;
  assign bus.match_size  = r_match_size;
  assign bus.match_dxky  = r_match_dxky;
  assign bus.match_dwire = r_match_dwire;
  assign bus.clst_count  = r_count;
  assign bus.clst_ovf    = r_ovf;

endmodule
